// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Consumes a byte stream (16-bit word count, then big-endian 32-bit words),
// issues one write strobe per assembled word and keeps the CPU held in reset
// until the whole image has been written.
module imem_loader #(
    parameter int IMEM_SIZE = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        WE,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [15:0] MAX_WORDS = 16'(IMEM_SIZE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [15:0] len_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_idx_r;

    logic        accept_s;
    logic [15:0] len_full_s;
    logic        len_bad_s;
    logic [15:0] word_next_s;
    logic        rearm_s;

    // in_ready is registered and mirrors the current state, so it is a safe
    // qualifier for the handshake in the same cycle.
    assign accept_s      = in_valid && in_ready;
    assign len_full_s    = {len_r[15:8], in_data};
    assign len_bad_s     = (len_full_s == 16'd0) || (len_full_s > MAX_WORDS);
    assign word_next_s   = word_idx_r + 16'd1;
    assign rearm_s       = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    assign words_written = word_idx_r;

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic for the load sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = LEN_HI;
                else       next_s = IDLE;
            end
            LEN_HI: begin
                if (accept_s) next_s = LEN_LO;
                else          next_s = LEN_HI;
            end
            LEN_LO: begin
                if (accept_s) begin
                    if (len_bad_s) next_s = ERR;
                    else           next_s = DATA;
                end else begin
                    next_s = LEN_LO;
                end
            end
            DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) next_s = WRITE;
                else                                  next_s = DATA;
            end
            WRITE: begin
                if (word_next_s == len_r) next_s = DONE;
                else                      next_s = DATA;
            end
            DONE: begin
                if (start) next_s = LEN_HI;
                else       next_s = DONE;
            end
            ERR: begin
                if (start) next_s = LEN_HI;
                else       next_s = ERR;
            end
            default: next_s = IDLE;
        endcase
    end

    // Registered outputs (decoded from the next state) and load datapath.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            in_ready   <= 1'b0;
            WE         <= 1'b0;
            W_Addr     <= 32'd0;
            W_Ins      <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_r      <= 16'd0;
            word_idx_r <= 16'd0;
            byte_idx_r <= 2'd0;
        end else begin
            in_ready <= (next_s == LEN_HI) || (next_s == LEN_LO) || (next_s == DATA);
            WE       <= (next_s == WRITE);
            cpu_hold <= (next_s != DONE);
            done     <= (next_s == DONE);
            error    <= (next_s == ERR);

            if (rearm_s) begin
                word_idx_r <= 16'd0;
                byte_idx_r <= 2'd0;
            end

            case (state_r)
                LEN_HI: if (accept_s) len_r[15:8] <= in_data;
                LEN_LO: if (accept_s) len_r[7:0]  <= in_data;
                DATA: begin
                    if (accept_s) begin
                        W_Ins      <= {W_Ins[23:0], in_data};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        // Address is latched with the final byte so it is
                        // stable for the whole WRITE cycle.
                        if (byte_idx_r == 2'd3) begin
                            W_Addr <= {14'd0, word_idx_r, 2'b00};
                        end
                    end
                end
                WRITE:   word_idx_r <= word_next_s;
                default: ;
            endcase
        end
    end

endmodule
